// File: rtl/rr_arbiter_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter_fsm_pkg                                              |
// | Purpose  : Shared definitions for the round-robin arbiter: FSM state       |
// |            encoding and the rotate-and-priority-encode helper.             |
// | Contents : c_IDLE / c_GRANT state codes, pick_t result type, rr_encode()   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package rr_arbiter_fsm_pkg;

  // State encoding, explicit 1-bit width.
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  // The helper works on a fixed 16-bit vector so it can serve every legal N.
  localparam int c_MAX_N = 16;
  localparam int c_IDX_W = 4;

  typedef struct packed {
    logic               found;
    logic [c_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n.
  // Only the low n bits of req are considered.
  function automatic pick_t rr_encode(input logic [c_MAX_N-1:0] req,
                                      input int n,
                                      input int ptr);
    pick_t res;
    int    j;
    res = '0;
    for (int i = 0; i < c_MAX_N; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (!res.found && req[j]) begin
          res.found = 1'b1;
          res.idx   = c_IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_fsm_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Purpose  : Combinational round-robin selector. Masks out excluded          |
// |            requesters, then picks the first remaining request at or after  |
// |            the pointer (wrapping).                                         |
// | Ports    : i_req    [N]   request vector                                   |
// |            i_ptr    [IDW] highest-priority index                           |
// |            i_excl   [N]   requesters that may not win this pick            |
// |            o_onehot [N]   one-hot winner (zero if none)                    |
// |            o_idx    [IDW] winner index (zero if none)                      |
// |            o_any          a winner exists                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_pick
  import rr_arbiter_fsm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic [N-1:0]   i_excl,
  output logic [N-1:0]   o_onehot,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  logic [N-1:0]       w_masked;
  logic [c_MAX_N-1:0] w_req_ext;
  pick_t              w_enc;

  assign w_masked  = i_req & ~i_excl;
  assign w_req_ext = c_MAX_N'(w_masked);
  assign w_enc     = rr_encode(w_req_ext, N, int'(i_ptr));

  assign o_any    = w_enc.found;
  assign o_idx    = w_enc.found ? w_enc.idx[IDW-1:0] : '0;
  assign o_onehot = w_enc.found ? (N'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter_fsm                                                  |
// | Purpose  : N-way round-robin arbiter with a maximum-hold limit. Grants are |
// |            registered and one-hot so they can drive the resource mux.      |
// | Ports    : i_clock            rising-edge clock                            |
// |            i_reset            synchronous reset, active low                |
// |            i_req      [N]     level-sensitive requests                     |
// |            o_gnt      [N]     one-hot grant, zero when idle                |
// |            o_gnt_valid        any grant set                                |
// |            o_gnt_id   [IDW]   current owner index, zero when idle          |
// |            o_hold_cnt [HW]    cycles the owner has held the grant          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_arbiter_fsm
  import rr_arbiter_fsm_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N),
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_gnt,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id,
  output logic [HW-1:0]  o_hold_cnt
);

  logic [0:0]     r_state;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic [HW-1:0]  r_hold;
  logic [IDW-1:0] r_ptr;

  logic [0:0]     w_state_nxt;
  logic [N-1:0]   w_gnt_nxt;
  logic [IDW-1:0] w_gnt_id_nxt;
  logic [HW-1:0]  w_hold_nxt;
  logic [IDW-1:0] w_ptr_nxt;

  logic           w_owner_req;
  logic           w_at_max;
  logic [N-1:0]   w_excl;
  logic [N-1:0]   w_pick_oh;
  logic [IDW-1:0] w_pick_idx;
  logic           w_pick_any;

  logic           w_new_grant;
  logic           w_inc;
  logic           w_restart;
  logic           w_go_idle;

  assign w_owner_req = |(i_req & r_gnt);
  assign w_at_max    = (r_hold == HW'(MAX_HOLD));

  // The owner is only shut out of the pick when its hold window has expired
  // while it still requests; otherwise its bit is either clear or irrelevant.
  assign w_excl = (r_state == c_GRANT && w_owner_req && w_at_max) ? r_gnt : '0;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .i_excl   (w_excl),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // State register and all datapath registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state  <= c_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_hold   <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_hold   <= w_hold_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  // Next-state and action decode.
  always_comb begin
    w_state_nxt = r_state;
    w_new_grant = 1'b0;
    w_inc       = 1'b0;
    w_restart   = 1'b0;
    w_go_idle   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = c_GRANT;
          w_new_grant = 1'b1;
        end
      end
      c_GRANT: begin
        if (!w_owner_req) begin
          // Owner released: hand over on the same edge, or fall idle.
          if (w_pick_any) begin
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = c_IDLE;
            w_go_idle   = 1'b1;
          end
        end else if (!w_at_max) begin
          w_inc = 1'b1;
        end else if (w_pick_any) begin
          w_new_grant = 1'b1;
        end else begin
          // Nobody else waiting: the owner keeps going on a fresh window.
          w_restart = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_go_idle   = 1'b1;
      end
    endcase
  end

  // Next register values for grant, owner id, hold counter and pointer.
  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_hold_nxt   = r_hold;
    w_ptr_nxt    = r_ptr;
    if (w_new_grant) begin
      w_gnt_nxt    = w_pick_oh;
      w_gnt_id_nxt = w_pick_idx;
      w_hold_nxt   = HW'(1);
      w_ptr_nxt    = (w_pick_idx == IDW'(N - 1)) ? '0 : w_pick_idx + IDW'(1);
    end else if (w_inc) begin
      w_hold_nxt = r_hold + HW'(1);
    end else if (w_restart) begin
      w_hold_nxt = HW'(1);
    end else if (w_go_idle) begin
      w_gnt_nxt    = '0;
      w_gnt_id_nxt = '0;
      w_hold_nxt   = '0;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = |r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_hold_cnt  = r_hold;

endmodule
`default_nettype wire
